// File: rtl/sm83_irq_ctrl.sv
// -----------------------------------------------------------------------------
// sm83_irq_ctrl
//
// Interrupt responder for the SM83 core. It owns the IF (flag) and IE (enable)
// registers and edge-detects the peripheral request lines. When the CPU has
// IME set and an enabled flag is pending, it requests dispatch and presents the
// RST-style vector of the highest-priority source (bit 0 = highest). The
// vector is latched on entry to the request state and held until the CPU acks
// or cancels the request.
//
// Ports
//   clk        core clock, all state on the rising edge
//   rst        asynchronous reset, active-high
//   bus_addr   CPU address
//   bus_wr     single-cycle write strobe
//   bus_rd     single-cycle read strobe
//   bus_wdata  write data
//   bus_hit    combinational: address decodes to IF or IE
//   bus_rdata  registered read data, valid the cycle after bus_rd, held otherwise
//   irq_src    peripheral request levels; a rising edge sets the IF bit
//   ime        CPU interrupt master enable
//   irq_req    dispatch request to the CPU
//   irq_vec    dispatch vector, stable while irq_req is high
//   irq_ack    CPU accepts dispatch (only meaningful while irq_req is high)
//   wake       combinational |(IE & IF), HALT exit, independent of ime
// -----------------------------------------------------------------------------
module sm83_irq_ctrl #(
    parameter int          NUM_IRQ  = 5,
    parameter logic [15:0] IF_ADDR  = 16'hFF0F,
    parameter logic [15:0] IE_ADDR  = 16'hFFFF,
    parameter logic [15:0] VEC_BASE = 16'h0040
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        bus_addr,
    input  logic               bus_wr,
    input  logic               bus_rd,
    input  logic [7:0]         bus_wdata,
    output logic               bus_hit,
    output logic [7:0]         bus_rdata,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               ime,
    output logic               irq_req,
    output logic [15:0]        irq_vec,
    input  logic               irq_ack,
    output logic               wake
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_COOL = 2'd2
    } state_t;

    // Index of the lowest set bit (highest priority); scanning downward lets
    // the lowest set bit be the last one written.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] vec);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            r = vec[i] ? IDX_W'(i) : r;
        end
        return r;
    endfunction

    // IF reads back with unimplemented upper bits as ones.
    function automatic logic [7:0] if_read_value(input logic [NUM_IRQ-1:0] flags);
        logic [7:0] r;
        r = 8'hFF;
        for (int i = 0; i < NUM_IRQ; i++) begin
            r[i] = flags[i];
        end
        return r;
    endfunction

    state_t               state_r;
    logic [NUM_IRQ-1:0]   src_prev_r;
    logic [NUM_IRQ-1:0]   if_r;
    logic [7:0]           ie_r;
    logic [IDX_W-1:0]     idx_r;
    logic                 irq_req_r;
    logic [15:0]          irq_vec_r;
    logic [7:0]           rdata_r;

    logic [NUM_IRQ-1:0]   set_vec_s;
    logic [NUM_IRQ-1:0]   pending_s;
    logic [IDX_W-1:0]     pend_idx_s;
    logic                 if_wr_s;
    logic                 ie_wr_s;
    logic                 ack_take_s;
    logic [NUM_IRQ-1:0]   if_wr_val_s;
    logic [NUM_IRQ-1:0]   ack_mask_s;
    logic [NUM_IRQ-1:0]   if_next_s;
    logic [7:0]           rd_mux_s;

    assign set_vec_s  = irq_src & ~src_prev_r;
    assign pending_s  = ie_r[NUM_IRQ-1:0] & if_r;
    assign pend_idx_s = lowest_set(pending_s);
    assign if_wr_s    = bus_wr && (bus_addr == IF_ADDR);
    assign ie_wr_s    = bus_wr && (bus_addr == IE_ADDR);
    // An ack only counts while a request is actually outstanding.
    assign ack_take_s = (state_r == ST_REQ) && irq_ack;

    // IF update order: bus write, then ack clear, then new edges ORed in so a
    // fresh edge always survives a coincident write or ack.
    assign if_wr_val_s = if_wr_s ? bus_wdata[NUM_IRQ-1:0] : if_r;
    assign ack_mask_s  = ack_take_s ? (NUM_IRQ'(1) << idx_r) : '0;
    assign if_next_s   = (if_wr_val_s & ~ack_mask_s) | set_vec_s;

    assign bus_hit   = (bus_addr == IF_ADDR) || (bus_addr == IE_ADDR);
    assign wake      = |pending_s;
    assign irq_req   = irq_req_r;
    assign irq_vec   = irq_vec_r;
    assign bus_rdata = rdata_r;

    // Read mux; sampled from current register values so a same-cycle write
    // is not visible to the read.
    always_comb begin
        rd_mux_s = 8'h00;
        if (bus_addr == IF_ADDR) begin
            rd_mux_s = if_read_value(if_r);
        end else if (bus_addr == IE_ADDR) begin
            rd_mux_s = ie_r;
        end else begin
            rd_mux_s = 8'h00;
        end
    end

    // Edge-capture flops plus the IF and IE registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_prev_r <= '0;
            if_r       <= '0;
            ie_r       <= 8'h00;
        end else begin
            src_prev_r <= irq_src;
            if_r       <= if_next_s;
            if (ie_wr_s) begin
                ie_r <= bus_wdata;
            end
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= 8'h00;
        end else if (bus_rd) begin
            rdata_r <= rd_mux_s;
        end
    end

    // Dispatch FSM. The vector is latched on entry to REQ and frozen there;
    // COOL gives the CPU one cycle to clear IME before pending is re-evaluated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            irq_req_r <= 1'b0;
            irq_vec_r <= VEC_BASE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ime && (|pending_s)) begin
                        state_r   <= ST_REQ;
                        idx_r     <= pend_idx_s;
                        irq_req_r <= 1'b1;
                        irq_vec_r <= VEC_BASE + 16'({pend_idx_s, 3'b000});
                    end
                end
                ST_REQ: begin
                    if (irq_ack) begin
                        state_r   <= ST_COOL;
                        irq_req_r <= 1'b0;
                    end else if (!ime) begin
                        // Cancelled: IF stays as is, re-arbitrated from IDLE.
                        state_r   <= ST_IDLE;
                        irq_req_r <= 1'b0;
                    end
                end
                ST_COOL: begin
                    state_r   <= ST_IDLE;
                    irq_req_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    irq_req_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sm83_irq_ctrl
//
// Table of per-cycle stimulus records with the expected outputs after the
// clock edge; expected read data goes through a scoreboard queue and is popped
// when the registered read data is due. A hand-written sequence covers reset
// asserted in the middle of a request.
// -----------------------------------------------------------------------------
module tb_sm83_irq_ctrl;

    localparam logic [15:0] A_IF = 16'hFF0F;
    localparam logic [15:0] A_IE = 16'hFFFF;
    localparam logic [15:0] A_NO = 16'h1234;

    logic        clk;
    logic        rst;
    logic [15:0] bus_addr;
    logic        bus_wr;
    logic        bus_rd;
    logic [7:0]  bus_wdata;
    logic        bus_hit;
    logic [7:0]  bus_rdata;
    logic [4:0]  irq_src;
    logic        ime;
    logic        irq_req;
    logic [15:0] irq_vec;
    logic        irq_ack;
    logic        wake;

    sm83_irq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_wdata (bus_wdata),
        .bus_hit   (bus_hit),
        .bus_rdata (bus_rdata),
        .irq_src   (irq_src),
        .ime       (ime),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .irq_ack   (irq_ack),
        .wake      (wake)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic        rd;
        logic [7:0]  wdata;
        logic [4:0]  src;
        logic        ime;
        logic        ack;
        logic        exp_req;
        logic [15:0] exp_vec;
        logic        exp_wake;
        logic        rd_chk;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sb_q[$];
    int         n_cmp;
    int         n_err;
    int         cur_step;

    task automatic add(input logic [15:0] addr, input logic wr, input logic rd,
                       input logic [7:0] wdata, input logic [4:0] src,
                       input logic im, input logic ack, input logic e_req,
                       input logic [15:0] e_vec, input logic e_wake,
                       input logic rchk, input logic [7:0] e_rd);
        vec_t v;
        v.addr = addr; v.wr = wr; v.rd = rd; v.wdata = wdata; v.src = src;
        v.ime = im; v.ack = ack; v.exp_req = e_req; v.exp_vec = e_vec;
        v.exp_wake = e_wake; v.rd_chk = rchk; v.exp_rd = e_rd;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h, expected %h", name, cur_step, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, then compare outputs after the edge.
    task automatic step(input vec_t v);
        logic exp_hit;
        logic [7:0] e;
        bus_addr  = v.addr;
        bus_wr    = v.wr;
        bus_rd    = v.rd;
        bus_wdata = v.wdata;
        irq_src   = v.src;
        ime       = v.ime;
        irq_ack   = v.ack;
        if (v.rd_chk) sb_q.push_back(v.exp_rd);
        #1;
        exp_hit = (v.addr == A_IF) || (v.addr == A_IE);
        chk("bus_hit", {15'd0, bus_hit}, {15'd0, exp_hit});
        @(posedge clk);
        #1;
        chk("irq_req", {15'd0, irq_req}, {15'd0, v.exp_req});
        chk("irq_vec", irq_vec, v.exp_vec);
        chk("wake", {15'd0, wake}, {15'd0, v.exp_wake});
        if (v.rd_chk) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 16'd1, 16'd0);
            end else begin
                e = sb_q.pop_front();
                chk("bus_rdata", {8'd0, bus_rdata}, {8'd0, e});
            end
        end
        cur_step++;
    endtask

    task automatic idle_vec(output vec_t v, input logic im);
        v.addr = A_NO; v.wr = 1'b0; v.rd = 1'b0; v.wdata = 8'h00; v.src = 5'd0;
        v.ime = im; v.ack = 1'b0; v.exp_req = 1'b0; v.exp_vec = 16'h0040;
        v.exp_wake = 1'b0; v.rd_chk = 1'b0; v.exp_rd = 8'h00;
    endtask

    initial begin
        vec_t v;
        n_cmp = 0; n_err = 0; cur_step = 0;
        rst = 1'b1;
        bus_addr = A_NO; bus_wr = 1'b0; bus_rd = 1'b0; bus_wdata = 8'h00;
        irq_src = 5'd0; ime = 1'b0; irq_ack = 1'b0;

        //  addr  wr    rd    wdata  src       ime   ack   req   vec       wake  rchk  rdata
        // Two sources, priority order, ack clears only the dispatched bit.
        add(A_IE, 1'b1, 1'b0, 8'h1F, 5'b00000, 1'b1, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00110, 1'b1, 1'b0, 1'b0, 16'h0040, 1'b1, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b0, 1'b1, 16'h0048, 1'b1, 1'b0, 8'h00);
        add(A_IF, 1'b0, 1'b1, 8'h00, 5'b00000, 1'b1, 1'b0, 1'b1, 16'h0048, 1'b1, 1'b1, 8'hE6);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b1, 1'b0, 16'h0048, 1'b1, 1'b0, 8'h00);
        add(A_IF, 1'b0, 1'b1, 8'h00, 5'b00000, 1'b1, 1'b0, 1'b0, 16'h0048, 1'b1, 1'b1, 8'hE4);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b0, 1'b1, 16'h0050, 1'b1, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b1, 1'b0, 16'h0050, 1'b0, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b0, 1'b0, 16'h0050, 1'b0, 1'b0, 8'h00);
        // ime=0: TIMER pending wakes but never requests; reads and read hold.
        add(A_IE, 1'b1, 1'b0, 8'h04, 5'b00000, 1'b0, 1'b0, 1'b0, 16'h0050, 1'b0, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00100, 1'b0, 1'b0, 1'b0, 16'h0050, 1'b1, 1'b0, 8'h00);
        add(A_IF, 1'b0, 1'b1, 8'h00, 5'b00000, 1'b0, 1'b0, 1'b0, 16'h0050, 1'b1, 1'b1, 8'hE4);
        add(A_IE, 1'b0, 1'b1, 8'h00, 5'b00000, 1'b0, 1'b0, 1'b0, 16'h0050, 1'b1, 1'b1, 8'h04);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b0, 1'b0, 1'b0, 16'h0050, 1'b1, 1'b1, 8'h04);
        add(A_NO, 1'b0, 1'b1, 8'h00, 5'b00000, 1'b0, 1'b0, 1'b0, 16'h0050, 1'b1, 1'b1, 8'h00);
        add(A_IF, 1'b1, 1'b0, 8'h00, 5'b00000, 1'b0, 1'b0, 1'b0, 16'h0050, 1'b0, 1'b0, 8'h00);
        // VBLANK in REQ, JOYPAD arrives later: vector frozen, then 0x0060.
        add(A_IE, 1'b1, 1'b0, 8'h1F, 5'b00000, 1'b1, 1'b0, 1'b0, 16'h0050, 1'b0, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00001, 1'b1, 1'b0, 1'b0, 16'h0050, 1'b1, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b10000, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b1, 1'b0, 16'h0040, 1'b1, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b0, 1'b0, 16'h0040, 1'b1, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b0, 1'b1, 16'h0060, 1'b1, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b1, 1'b0, 16'h0060, 1'b0, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b0, 1'b0, 16'h0060, 1'b0, 1'b0, 8'h00);
        // Edge beats a same-cycle IF write, and beats a coincident ack clear.
        add(A_IF, 1'b1, 1'b0, 8'h00, 5'b00010, 1'b0, 1'b0, 1'b0, 16'h0060, 1'b1, 1'b0, 8'h00);
        add(A_IF, 1'b0, 1'b1, 8'h00, 5'b00000, 1'b0, 1'b0, 1'b0, 16'h0060, 1'b1, 1'b1, 8'hE2);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b0, 1'b1, 16'h0048, 1'b1, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00010, 1'b1, 1'b1, 1'b0, 16'h0048, 1'b1, 1'b0, 8'h00);
        add(A_IF, 1'b0, 1'b1, 8'h00, 5'b00000, 1'b1, 1'b0, 1'b0, 16'h0048, 1'b1, 1'b1, 8'hE2);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b0, 1'b1, 16'h0048, 1'b1, 1'b0, 8'h00);
        // Cancel by dropping ime, IF untouched, then re-request same vector.
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b0, 1'b0, 1'b0, 16'h0048, 1'b1, 1'b0, 8'h00);
        add(A_IF, 1'b0, 1'b1, 8'h00, 5'b00000, 1'b0, 1'b0, 1'b0, 16'h0048, 1'b1, 1'b1, 8'hE2);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b0, 1'b1, 16'h0048, 1'b1, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b1, 1'b0, 16'h0048, 1'b0, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b0, 1'b0, 1'b0, 16'h0048, 1'b0, 1'b0, 8'h00);
        // Ack outside REQ is ignored; same-cycle read+write returns old IE.
        add(A_IF, 1'b1, 1'b0, 8'h01, 5'b00000, 1'b0, 1'b0, 1'b0, 16'h0048, 1'b1, 1'b0, 8'h00);
        add(A_NO, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b0, 1'b1, 1'b0, 16'h0048, 1'b1, 1'b0, 8'h00);
        add(A_IF, 1'b0, 1'b1, 8'h00, 5'b00000, 1'b0, 1'b0, 1'b0, 16'h0048, 1'b1, 1'b1, 8'hE1);
        add(A_IE, 1'b1, 1'b1, 8'h00, 5'b00000, 1'b0, 1'b0, 1'b0, 16'h0048, 1'b0, 1'b1, 8'h1F);
        add(A_IE, 1'b1, 1'b0, 8'h1F, 5'b00000, 1'b0, 1'b0, 1'b0, 16'h0048, 1'b1, 1'b0, 8'h00);

        // Reset state while rst is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_irq_req", {15'd0, irq_req}, 16'd0);
        chk("rst_irq_vec", irq_vec, 16'h0040);
        chk("rst_rdata", {8'd0, bus_rdata}, 16'd0);
        chk("rst_wake", {15'd0, wake}, 16'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Reset in the middle of a VBLANK request (IF=01, IE=1F).
        idle_vec(v, 1'b1);
        v.exp_req = 1'b1; v.exp_vec = 16'h0040; v.exp_wake = 1'b1;
        step(v);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_req", {15'd0, irq_req}, 16'd0);
        chk("rst_mid_wake", {15'd0, wake}, 16'd0);
        ime = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_vec(v, 1'b0);
        v.addr = A_IF; v.rd = 1'b1; v.rd_chk = 1'b1; v.exp_rd = 8'hE0;
        step(v);
        idle_vec(v, 1'b0);
        v.addr = A_IE; v.rd = 1'b1; v.rd_chk = 1'b1; v.exp_rd = 8'h00;
        step(v);
        idle_vec(v, 1'b1);
        step(v);

        chk("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
